// File: rtl/regfile_access_ctrl.sv
// Host-side access controller for a 32x32 register file port: single writes,
// paired reads and full dumps. Optional write read-back check under RFAC_READBACK_EN.
module regfile_access_ctrl #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr_a,
  input  logic [AW-1:0] cmd_addr_b,
  input  logic [DW-1:0] cmd_wdata,
  input  logic          dump_start,
  output logic          dump_busy,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [AW-1:0] rsp_addr_a,
  output logic [DW-1:0] rsp_data_a,
  output logic [DW-1:0] rsp_data_b,
  output logic          wr_err,
  output logic          RegWr,
  output logic          RegDst,
  output logic [AW-1:0] Rs,
  output logic [AW-1:0] Rt,
  output logic [AW-1:0] Rd,
  output logic [DW-1:0] busW,
  input  logic [DW-1:0] busA,
  input  logic [DW-1:0] busB
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
`ifdef RFAC_READBACK_EN
    S_VERIFY   = 3'd2,
`endif
    S_READ     = 3'd3,
    S_RSP      = 3'd4,
    S_DUMP_RD  = 3'd5,
    S_DUMP_RSP = 3'd6
  } state_t;

  state_t state, state_nxt;

  localparam logic [AW-1:0] LAST_PAIR = AW'(NREGS - 2);

  // Both streams transfer on a rising edge where valid && ready are high.
  // A response stays stable while rsp_valid && !rsp_ready; ready without valid is ignored.
  assign cmd_ready = (state == S_IDLE) && !dump_start;
  assign RegDst    = 1'b1;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (dump_start)     state_nxt = S_DUMP_RD;
        else if (cmd_valid) state_nxt = cmd_wr ? S_WRITE : S_READ;
      end
`ifdef RFAC_READBACK_EN
      S_WRITE:    state_nxt = S_VERIFY;
      S_VERIFY:   state_nxt = S_IDLE;
`else
      S_WRITE:    state_nxt = S_IDLE;
`endif
      S_READ:     state_nxt = S_RSP;
      S_RSP:      if (rsp_ready) state_nxt = S_IDLE;
      S_DUMP_RD:  state_nxt = S_DUMP_RSP;
      S_DUMP_RSP: if (rsp_ready) state_nxt = (Rs == LAST_PAIR) ? S_IDLE : S_DUMP_RD;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      RegWr      <= 1'b0;
      Rs         <= '0;
      Rt         <= '0;
      Rd         <= '0;
      busW       <= '0;
      rsp_valid  <= 1'b0;
      rsp_addr_a <= '0;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
      dump_busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dump_start) begin
            dump_busy <= 1'b1;
            Rs        <= '0;
            Rt        <= AW'(1);
          end else if (cmd_valid) begin
            if (cmd_wr) begin
              Rd    <= cmd_addr_a;
              busW  <= cmd_wdata;
              RegWr <= 1'b1;
            end else begin
              Rs <= cmd_addr_a;
              Rt <= cmd_addr_b;
            end
          end
        end
        S_WRITE: begin
          RegWr <= 1'b0;
`ifdef RFAC_READBACK_EN
          Rt    <= Rd;
`endif
        end
        S_READ, S_DUMP_RD: begin
          rsp_data_a <= busA;
          rsp_data_b <= busB;
          rsp_addr_a <= Rs;
          rsp_valid  <= 1'b1;
        end
        S_RSP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        S_DUMP_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (Rs == LAST_PAIR) begin
              dump_busy <= 1'b0;
            end else begin
              Rs <= Rs + AW'(2);
              Rt <= Rt + AW'(2);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RFAC_READBACK_EN
  // Register 0 is hardwired, so a write there must read back as zero.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      wr_err <= 1'b0;
    end else if (state == S_VERIFY) begin
      if (busB != ((Rd == '0) ? '0 : busW)) wr_err <= 1'b1;
    end
  end
`else
  assign wr_err = 1'b0;
`endif

endmodule
